// File: rtl/io_mailbox_muldiv_pkg.sv
// ============================================================================
// io_mailbox_muldiv_pkg
// Shared encodings for the I/O mailbox multiply/divide responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_mailbox_muldiv_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_MULU = 2'b00;
   localparam op_t OP_DIVU = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int ST_ACK   = 0;
   localparam int ST_BUSY  = 1;
   localparam int ST_ERR   = 2;
   localparam int ST_OP_LO = 3;
   localparam int ST_OP_HI = 4;

   // Encodings 10 and 11 are reserved; only the upper op bit distinguishes them.
   function automatic logic op_reserved(input op_t op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_mailbox_muldiv_if.sv
// ============================================================================
// io_mailbox_muldiv_if
// Mailbox bus between the CPU I/O ports and the multiply/divide responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface io_mailbox_muldiv_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      cmd;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [31:0]      status;
   logic [WIDTH-1:0] result;

   modport master (
      output cmd, opa, opb,
      input  status, result
   );

   modport slave (
      input  cmd, opa, opb,
      output status, result
   );
endinterface

`default_nettype wire

// File: rtl/io_muldiv_core.sv
// ============================================================================
// io_muldiv_core
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             i_start,
   input  wire logic             i_step,
   input  wire logic             i_div,
   input  wire logic [WIDTH-1:0] i_opa,
   input  wire logic [WIDTH-1:0] i_opb,
   output logic      [WIDTH-1:0] o_hi,
   output logic      [WIDTH-1:0] o_lo
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic               r_div;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [2*WIDTH-1:0] w_div_next;

   // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: acc = {rem, quot}; shift one dividend bit into rem and try to subtract.
   assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
   assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_b;
   assign w_div_next  = {(w_div_ge ? w_div_rem : w_div_shift[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc <= '0;
         r_b   <= '0;
         r_div <= 1'b0;
      end else if (i_start) begin
         r_div <= i_div;
         r_acc <= {{WIDTH{1'b0}}, (i_div ? i_opa : i_opb)};
         r_b   <= i_div ? i_opb : i_opa;
      end else if (i_step) begin
         r_acc <= r_div ? w_div_next : w_mul_next;
      end
   end

   assign o_hi = r_acc[2*WIDTH-1:WIDTH];
   assign o_lo = r_acc[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/io_mailbox_muldiv.sv
// ============================================================================
// io_mailbox_muldiv
// Toggle-handshake responder: reads cmd/opa/opb, runs mul/div, reports status/result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_mailbox_muldiv
   import io_mailbox_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic              clock,
   input  wire logic              reset,
   io_mailbox_muldiv_if.slave     bus
);

   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   op_t              r_op;
   logic             r_seq;
   logic             r_fault;
   logic             r_fault_dz;
   logic             r_ack;
   logic             r_busy;
   logic             r_err;
   op_t              r_last_op;
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;

   logic             w_load;
   op_t              w_cmd_op;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_core_lo;
   logic             w_unused;

   assign w_cmd_op = bus.cmd[2:1];
   assign w_load   = (r_state == S_IDLE) && (bus.cmd[0] != r_ack);
   assign w_unused = &{1'b0, bus.cmd[31:4]};

   io_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clock   (clock),
      .reset   (reset),
      .i_start (w_load),
      .i_step  (r_state == S_CALC),
      .i_div   (w_cmd_op == OP_DIVU),
      .i_opa   (bus.opa),
      .i_opb   (bus.opb),
      .o_hi    (w_core_hi),
      .o_lo    (w_core_lo)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= OP_MULU;
         r_seq      <= 1'b0;
         r_fault    <= 1'b0;
         r_fault_dz <= 1'b0;
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_last_op  <= OP_MULU;
         r_res_hi   <= '0;
         r_res_lo   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_seq  <= bus.cmd[0];
                  r_op   <= w_cmd_op;
                  r_busy <= 1'b1;
                  r_cnt  <= CNT_LAST;
                  if (op_reserved(w_cmd_op)) begin
                     r_fault    <= 1'b1;
                     r_fault_dz <= 1'b0;
                     r_state    <= S_DONE;
                  end else if ((w_cmd_op == OP_DIVU) && (bus.opb == '0)) begin
                     r_fault    <= 1'b1;
                     r_fault_dz <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_fault    <= 1'b0;
                     r_fault_dz <= 1'b0;
                     r_state    <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_ack     <= r_seq;
               r_busy    <= 1'b0;
               r_err     <= r_fault;
               r_last_op <= r_op;
               if (!r_fault) begin
                  r_res_hi <= w_core_hi;
                  r_res_lo <= w_core_lo;
               end else if (r_fault_dz) begin
                  // The core was loaded but never stepped, so its low half still holds the dividend.
                  r_res_hi <= w_core_lo;
                  r_res_lo <= '1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.status                   = '0;
      bus.status[ST_ACK]           = r_ack;
      bus.status[ST_BUSY]          = r_busy;
      bus.status[ST_ERR]           = r_err;
      bus.status[ST_OP_HI:ST_OP_LO] = r_last_op;
   end

   assign bus.result = bus.cmd[3] ? r_res_hi : r_res_lo;

endmodule

`default_nettype wire

// File: tb/tb_io_mailbox_muldiv.sv
// ============================================================================
// tb_io_mailbox_muldiv
// Directed self-checking bench for the I/O mailbox multiply/divide responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_mailbox_muldiv;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   io_mailbox_muldiv_if #(.WIDTH(32)) bus();

   io_mailbox_muldiv #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Drive a request at a negedge; returns at the negedge after the load edge.
   task automatic issue(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.cmd = c;
      bus.opa = a;
      bus.opb = b;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_ack(input logic exp, output int n);
      n = 0;
      while (bus.status[0] !== exp && n < 100) begin
         @(posedge clock);
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset();
      logic seen;
      reset   = 1'b1;
      bus.cmd = 32'h0;
      bus.opa = 32'h0;
      bus.opb = 32'h0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      checks++;
      if (bus.status !== 32'h0) begin
         errors++; $display("FAIL reset_status: got %h want %h", bus.status, 32'h0);
      end
      checks++;
      if (bus.result !== 32'h0) begin
         errors++; $display("FAIL reset_result: got %h want %h", bus.result, 32'h0);
      end
      seen = 1'b0;
      repeat (100) begin
         @(negedge clock);
         if (bus.status !== 32'h0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL idle_activity: got %b want %b", seen, 1'b0);
      end
   endtask

   task automatic test_mulu_max();
      int n;
      issue(32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (bus.status !== 32'h2) begin
         errors++; $display("FAIL mulu_busy: got %h want %h", bus.status, 32'h2);
      end
      wait_ack(1'b1, n);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL mulu_latency: got %0d want %0d", n, 33);
      end
      checks++;
      if (bus.result !== 32'h0000_0001) begin
         errors++; $display("FAIL mulu_lo: got %h want %h", bus.result, 32'h1);
      end
      checks++;
      if (bus.status !== 32'h1) begin
         errors++; $display("FAIL mulu_status: got %h want %h", bus.status, 32'h1);
      end
      bus.cmd = 32'h9;
      #1;
      checks++;
      if (bus.result !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL mulu_hi: got %h want %h", bus.result, 32'hFFFF_FFFE);
      end
   endtask

   task automatic test_divu();
      int n;
      issue(32'h2, 32'd100, 32'd7);
      wait_ack(1'b0, n);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL divu_latency: got %0d want %0d", n, 33);
      end
      checks++;
      if (bus.result !== 32'd14) begin
         errors++; $display("FAIL divu_quot: got %0d want %0d", bus.result, 14);
      end
      checks++;
      if (bus.status !== 32'h8) begin
         errors++; $display("FAIL divu_status: got %h want %h", bus.status, 32'h8);
      end
      bus.cmd = 32'hA;
      #1;
      checks++;
      if (bus.result !== 32'd2) begin
         errors++; $display("FAIL divu_rem: got %0d want %0d", bus.result, 2);
      end
   endtask

   task automatic test_div_zero();
      int n;
      issue(32'h3, 32'd5, 32'd0);
      wait_ack(1'b1, n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL dz_latency: got %0d want %0d", n, 1);
      end
      checks++;
      if (bus.status !== 32'hD) begin
         errors++; $display("FAIL dz_status: got %h want %h", bus.status, 32'hD);
      end
      checks++;
      if (bus.result !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL dz_lo: got %h want %h", bus.result, 32'hFFFF_FFFF);
      end
      bus.cmd = 32'hB;
      #1;
      checks++;
      if (bus.result !== 32'd5) begin
         errors++; $display("FAIL dz_hi: got %h want %h", bus.result, 32'd5);
      end
      @(negedge clock);
      issue(32'h0, 32'd6, 32'd7);
      wait_ack(1'b0, n);
      checks++;
      if (bus.result !== 32'd42) begin
         errors++; $display("FAIL dz_recover_result: got %0d want %0d", bus.result, 42);
      end
      checks++;
      if (bus.status !== 32'h0) begin
         errors++; $display("FAIL dz_err_clear: got %h want %h", bus.status, 32'h0);
      end
   endtask

   task automatic test_busy_toggle();
      int   n;
      logic bad;
      issue(32'h1, 32'd3, 32'd4);
      repeat (9) begin
         @(posedge clock);
         @(negedge clock);
      end
      bus.cmd = 32'h0;
      @(posedge clock);
      @(negedge clock);
      bus.cmd = 32'h1;
      bus.opa = 32'd9;
      wait_ack(1'b1, n);
      checks++;
      if (n !== 23) begin
         errors++; $display("FAIL busy_toggle_latency: got %0d want %0d", n, 23);
      end
      checks++;
      if (bus.result !== 32'd12) begin
         errors++; $display("FAIL busy_toggle_result: got %0d want %0d", bus.result, 12);
      end
      bad = 1'b0;
      repeat (50) begin
         @(negedge clock);
         if (bus.status[1] !== 1'b0 || bus.status[0] !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL busy_toggle_second_op: got %b want %b", bad, 1'b0);
      end
   endtask

   task automatic test_reserved();
      int n;
      issue(32'h4, 32'd123, 32'd456);
      wait_ack(1'b0, n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL rsv_latency: got %0d want %0d", n, 1);
      end
      checks++;
      if (bus.status !== 32'h14) begin
         errors++; $display("FAIL rsv_status: got %h want %h", bus.status, 32'h14);
      end
      checks++;
      if (bus.result !== 32'd12) begin
         errors++; $display("FAIL rsv_lo_kept: got %0d want %0d", bus.result, 12);
      end
      bus.cmd = 32'hC;
      #1;
      checks++;
      if (bus.result !== 32'd0) begin
         errors++; $display("FAIL rsv_hi_kept: got %0d want %0d", bus.result, 0);
      end
      @(negedge clock);
      bus.cmd = 32'h4;
   endtask

   task automatic test_back_to_back();
      int n;
      issue(32'h1, 32'd2, 32'd3);
      wait_ack(1'b1, n);
      checks++;
      if (bus.result !== 32'd6) begin
         errors++; $display("FAIL b2b_first: got %0d want %0d", bus.result, 6);
      end
      issue(32'h2, 32'd50, 32'd8);
      checks++;
      if (bus.status[1] !== 1'b1) begin
         errors++; $display("FAIL b2b_one_idle: got %b want %b", bus.status[1], 1'b1);
      end
      wait_ack(1'b0, n);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL b2b_latency: got %0d want %0d", n, 33);
      end
      checks++;
      if (bus.result !== 32'd6) begin
         errors++; $display("FAIL b2b_quot: got %0d want %0d", bus.result, 6);
      end
      bus.cmd = 32'hA;
      #1;
      checks++;
      if (bus.result !== 32'd2) begin
         errors++; $display("FAIL b2b_rem: got %0d want %0d", bus.result, 2);
      end
   endtask

   task automatic test_mid_reset();
      int   n;
      logic bad;
      issue(32'h1, 32'd11, 32'd13);
      repeat (15) begin
         @(posedge clock);
         @(negedge clock);
      end
      reset   = 1'b1;
      bus.cmd = 32'h0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (bus.status !== 32'h0) begin
         errors++; $display("FAIL rst_status: got %h want %h", bus.status, 32'h0);
      end
      checks++;
      if (bus.result !== 32'h0) begin
         errors++; $display("FAIL rst_lo: got %h want %h", bus.result, 32'h0);
      end
      bus.cmd = 32'h8;
      #1;
      checks++;
      if (bus.result !== 32'h0) begin
         errors++; $display("FAIL rst_hi: got %h want %h", bus.result, 32'h0);
      end
      bad = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.status !== 32'h0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL rst_no_resume: got %b want %b", bad, 1'b0);
      end
      issue(32'h1, 32'd11, 32'd13);
      wait_ack(1'b1, n);
      checks++;
      if (n !== 33) begin
         errors++; $display("FAIL rst_reissue_latency: got %0d want %0d", n, 33);
      end
      checks++;
      if (bus.result !== 32'd143) begin
         errors++; $display("FAIL rst_reissue_result: got %0d want %0d", bus.result, 143);
      end
   endtask

   initial begin
      test_reset();
      test_mulu_max();
      test_divu();
      test_div_zero();
      test_busy_toggle();
      test_reserved();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
